// File: rtl/cpu6_bus_if.sv
// CPU6 single-byte memory/I/O bus interface: setup / access (wait-stretched) / hold bus cycle.
// Optional access timeout is compiled in with `define CPU6_BUS_TIMEOUT_EN.
module cpu6_bus_if #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter must reach both MIN_WAIT-1 and TIMEOUT-1; beyond that it only saturates.
  localparam int CNT_TOP = (MIN_WAIT > TIMEOUT) ? MIN_WAIT : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
`ifdef CPU6_BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc_s;
  logic              min_met_s;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oe_q, oe_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  // cnt_q + 1 >= MIN_WAIT is the same as cnt_q >= MIN_WAIT-1 without an unsigned underflow
  assign cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign min_met_s = (cnt_inc_s >= (CNT_W + 1)'(MIN_WAIT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    oe_d        = oe_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          oe_d    = req_write;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = {CNT_W{1'b0}};
        rd_d    = ~write_q;
        wr_d    = write_q;
      end
      ACCESS: begin
        if (min_met_s && mem_ready) begin
          state_d     = HOLD;
          rsp_valid_d = 1'b1;
          if (!write_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
`ifdef CPU6_BUS_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d     = HOLD;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
`endif
        end else begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_inc_s[CNT_W-1:0];
          rd_d  = ~write_q;
          wr_d  = write_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  // Reset kills strobes and the write drive immediately, without waiting for a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      write_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      oe_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      oe_q        <= oe_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_oe    = oe_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;

endmodule

// File: tb/tb_cpu6_bus_if.sv
// Randomized transaction-level bench for cpu6_bus_if: two instances (MIN_WAIT 1 and 3).
module tb_cpu6_bus_if;

  localparam int TO_V = 8;

  logic        clock;
  logic        reset;
  logic        req_valid [2];
  logic        req_write [2];
  logic [15:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic        rsp_err   [2];
  logic [15:0] mem_addr  [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_oe    [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [7:0]  mem_rdata [2];
  logic        mem_ready [2];

  int          n_checks;
  int          n_fail;
  int          mw [2];
  logic [7:0]  exp_rd [2];

  cpu6_bus_if #(.ADDR_W(16), .DATA_W(8), .MIN_WAIT(1), .TIMEOUT(TO_V)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_oe(mem_oe[0]),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0])
  );

  cpu6_bus_if #(.ADDR_W(16), .DATA_W(8), .MIN_WAIT(3), .TIMEOUT(TO_V)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_oe(mem_oe[1]),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic garble(input int d);
    req_valid[d] = 1'($urandom_range(0, 1));
    req_write[d] = 1'($urandom_range(0, 1));
    req_addr[d]  = 16'($urandom);
    req_wdata[d] = 8'($urandom);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    check_eq({tag, "_rspv"},  32'(rsp_valid[d]), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rsp_rdata[d]), 32'd0);
    check_eq({tag, "_err"},   32'(rsp_err[d]),   32'd0);
    check_eq({tag, "_addr"},  32'(mem_addr[d]),  32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata[d]), 32'd0);
    check_eq({tag, "_strb"},  32'({mem_oe[d], mem_rd[d], mem_wr[d]}), 32'd0);
  endtask

  // One full transaction; rdly = ACCESS cycles with mem_ready low before it rises.
  task automatic run_txn(input int d, input bit wr, input logic [15:0] a,
                         input logic [7:0] wd, input logic [7:0] rdv, input int rdly);
    int  exp_w;
    int  w;
    int  oe_n;
    bit  exp_err;
    exp_err = 1'b0;
    exp_w   = (rdly + 1 > mw[d]) ? rdly + 1 : mw[d];
`ifdef CPU6_BUS_TIMEOUT_EN
    if (rdly >= TO_V) begin
      exp_err = 1'b1;
      exp_w   = TO_V;
    end
`endif
    check_eq("idle_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    mem_ready[d] = 1'b0;
    mem_rdata[d] = 8'($urandom);
    tick();
    check_eq("setup_ready", 32'(req_ready[d]), 32'd0);
    check_eq("setup_strb",  32'({mem_rd[d], mem_wr[d]}), 32'd0);
    check_eq("setup_addr",  32'(mem_addr[d]), 32'(a));
    check_eq("setup_wdata", 32'(mem_wdata[d]), 32'(wd));
    check_eq("setup_oe",    32'(mem_oe[d]), 32'(wr));
    oe_n = int'(mem_oe[d]);
    garble(d);
    tick();
    w = 0;
    while ((mem_rd[d] || mem_wr[d]) && w < 1100) begin
      check_eq("acc_dir",  32'({mem_rd[d], mem_wr[d]}), wr ? 32'd1 : 32'd2);
      check_eq("acc_addr", 32'(mem_addr[d]), 32'(a));
      check_eq("acc_oe",   32'(mem_oe[d]), 32'(wr));
      check_eq("acc_rspv", 32'(rsp_valid[d]), 32'd0);
      oe_n += int'(mem_oe[d]);
      mem_ready[d] = (w >= rdly);
      mem_rdata[d] = (w >= rdly) ? rdv : 8'($urandom);
      w++;
      garble(d);
      tick();
    end
    check_eq("strobe_width", 32'(w), 32'(exp_w));
    if (!wr && !exp_err) exp_rd[d] = rdv;
    check_eq("hold_rspv",  32'(rsp_valid[d]), 32'd1);
    check_eq("hold_err",   32'(rsp_err[d]), 32'(exp_err));
    check_eq("hold_rdata", 32'(rsp_rdata[d]), 32'(exp_rd[d]));
    check_eq("hold_addr",  32'(mem_addr[d]), 32'(a));
    check_eq("hold_oe",    32'(mem_oe[d]), 32'(wr));
    check_eq("hold_ready", 32'(req_ready[d]), 32'd0);
    oe_n += int'(mem_oe[d]);
    mem_ready[d] = 1'b0;
    tick();
    check_eq("idle_back",  32'(req_ready[d]), 32'd1);
    check_eq("idle_rspv",  32'(rsp_valid[d]), 32'd0);
    check_eq("idle_strb",  32'({mem_oe[d], mem_rd[d], mem_wr[d]}), 32'd0);
    check_eq("idle_addr",  32'(mem_addr[d]), 32'(a));
    check_eq("idle_rdata", 32'(rsp_rdata[d]), 32'(exp_rd[d]));
    check_eq("oe_cycles",  32'(oe_n), wr ? 32'(exp_w + 2) : 32'd0);
    req_valid[d] = 1'b0;
  endtask

  initial begin
    int d;
    int rdly;
    n_checks = 0;
    n_fail   = 0;
    mw[0]    = 1;
    mw[1]    = 3;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 16'h0000;
      req_wdata[i] = 8'h00;
      mem_rdata[i] = 8'h00;
      mem_ready[i] = 1'b0;
      exp_rd[i]    = 8'h00;
    end
    reset = 1'b0;
    #12;
    check_reset_vals(0, "rst0");
    check_reset_vals(1, "rst1");
    #12;
    reset = 1'b1;
    tick();
    check_reset_vals(0, "post0");

    // Directed cases from the plan
    run_txn(0, 1'b0, 16'h1234, 8'h00, 8'h5A, 0);
    run_txn(0, 1'b0, 16'h4321, 8'h00, 8'hA5, 0);
    run_txn(0, 1'b1, 16'h00FF, 8'hC3, 8'h00, 3);
    run_txn(1, 1'b0, 16'h0777, 8'h00, 8'h3C, 0);
    run_txn(1, 1'b1, 16'h0778, 8'h11, 8'h00, 1);
    run_txn(0, 1'b0, 16'hBEEF, 8'h00, 8'h99, TO_V);
    run_txn(0, 1'b0, 16'hCAFE, 8'h00, 8'h42, 1000);

    for (int n = 0; n < 60; n++) begin
      d    = int'($urandom_range(0, 1));
      rdly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 4));
      run_txn(d, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom), rdly);
    end

    // Reset during the second ACCESS cycle of a read
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 16'h0BEE;
    mem_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    check_eq("pre_kill_rd", 32'(mem_rd[0]), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals(0, "kill0");
    check_reset_vals(1, "kill1");
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    tick();
    check_reset_vals(0, "killhold");
    #3;
    reset = 1'b1;
    mem_ready[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("no_rsp_after_kill", 32'(rsp_valid[0]), 32'd0);
      check_eq("ready_after_kill",  32'(req_ready[0]), 32'd1);
    end
    mem_ready[0] = 1'b0;
    run_txn(0, 1'b0, 16'h2468, 8'h00, 8'h77, 0);
    run_txn(1, 1'b0, 16'h1357, 8'h00, 8'h88, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
